// File: rtl/banco_arbiter.sv
// banco_arbiter: two-requester round-robin front end for a dual-read-port
// register bank. One transaction is in flight at a time: a grant in IDLE,
// an ISSUE cycle that drives the bank, an optional CAPTURE cycle for reads,
// and a RESP cycle that is held until the owner consumes the response.
module banco_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic              i_req0_we,
    input  logic [ADDR_W-1:0] i_req0_addr_a,
    input  logic [ADDR_W-1:0] i_req0_addr_b,
    input  logic [DATA_W-1:0] i_req0_wdata,
    output logic              o_rsp0_valid,
    input  logic              i_rsp0_ready,
    output logic [DATA_W-1:0] o_rsp0_data_a,
    output logic [DATA_W-1:0] o_rsp0_data_b,

    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic              i_req1_we,
    input  logic [ADDR_W-1:0] i_req1_addr_a,
    input  logic [ADDR_W-1:0] i_req1_addr_b,
    input  logic [DATA_W-1:0] i_req1_wdata,
    output logic              o_rsp1_valid,
    input  logic              i_rsp1_ready,
    output logic [DATA_W-1:0] o_rsp1_data_a,
    output logic [DATA_W-1:0] o_rsp1_data_b,

    output logic [ADDR_W-1:0] o_bank_reg_a,
    output logic [ADDR_W-1:0] o_bank_reg_b,
    output logic              o_bank_rw,
    output logic [DATA_W-1:0] o_bank_wdata,
    input  logic [DATA_W-1:0] i_bank_rdata_a,
    input  logic [DATA_W-1:0] i_bank_rdata_b
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // r_owner is both the owner of the current transaction and the
    // round-robin pointer (the last requester granted). Reset to 1 so that
    // requester 0 wins the first tie.
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_bank_reg_a;
    logic [ADDR_W-1:0] r_bank_reg_b;
    logic [DATA_W-1:0] r_bank_wdata;
    logic [DATA_W-1:0] r_rsp0_data_a;
    logic [DATA_W-1:0] r_rsp0_data_b;
    logic [DATA_W-1:0] r_rsp1_data_a;
    logic [DATA_W-1:0] r_rsp1_data_b;

    logic              w_grant_any;
    logic              w_grant_id;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr_a;
    logic [ADDR_W-1:0] w_sel_addr_b;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_owner_rsp_ready;

    // Arbitration: only in IDLE and never while reset is asserted, so ready
    // drops the instant rst_n falls. On a tie the non-last requester wins.
    always_comb begin
        w_grant_any  = 1'b0;
        w_grant_id   = 1'b0;
        if (rst_n && (r_state == IDLE) && (i_req0_valid || i_req1_valid)) begin
            w_grant_any = 1'b1;
            if (i_req0_valid && i_req1_valid) begin
                w_grant_id = ~r_owner;
            end else begin
                w_grant_id = i_req1_valid;
            end
        end
        w_sel_we     = w_grant_id ? i_req1_we     : i_req0_we;
        w_sel_addr_a = w_grant_id ? i_req1_addr_a : i_req0_addr_a;
        w_sel_addr_b = w_grant_id ? i_req1_addr_b : i_req0_addr_b;
        w_sel_wdata  = w_grant_id ? i_req1_wdata  : i_req0_wdata;
    end

    assign o_req0_ready      = w_grant_any && !w_grant_id;
    assign o_req1_ready      = w_grant_any &&  w_grant_id;
    assign w_owner_rsp_ready = r_owner ? i_rsp1_ready : i_rsp0_ready;

    // Next-state logic: writes skip CAPTURE since no read data is needed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_any) w_state_next = ISSUE;
            ISSUE:   w_state_next = r_we ? RESP : CAPTURE;
            CAPTURE: w_state_next = RESP;
            RESP:    if (w_owner_rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the granted command; the bank address/data registers double as
    // the command latch so the bank ports hold their values between uses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= 1'b1;
            r_we         <= 1'b0;
            r_bank_reg_a <= '0;
            r_bank_reg_b <= '0;
            r_bank_wdata <= '0;
        end else if (w_grant_any) begin
            r_owner      <= w_grant_id;
            r_we         <= w_sel_we;
            r_bank_reg_a <= w_sel_addr_a;
            r_bank_reg_b <= w_sel_addr_b;
            r_bank_wdata <= w_sel_wdata;
        end
    end

    // Response data: write echo leaves data_b untouched; reads capture both
    // bank ports one cycle after the addresses were presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_data_a <= '0;
            r_rsp0_data_b <= '0;
            r_rsp1_data_a <= '0;
            r_rsp1_data_b <= '0;
        end else if ((r_state == ISSUE) && r_we) begin
            if (r_owner) r_rsp1_data_a <= r_bank_wdata;
            else         r_rsp0_data_a <= r_bank_wdata;
        end else if (r_state == CAPTURE) begin
            if (r_owner) begin
                r_rsp1_data_a <= i_bank_rdata_a;
                r_rsp1_data_b <= i_bank_rdata_b;
            end else begin
                r_rsp0_data_a <= i_bank_rdata_a;
                r_rsp0_data_b <= i_bank_rdata_b;
            end
        end
    end

    assign o_rsp0_valid  = (r_state == RESP) && !r_owner;
    assign o_rsp1_valid  = (r_state == RESP) &&  r_owner;
    assign o_rsp0_data_a = r_rsp0_data_a;
    assign o_rsp0_data_b = r_rsp0_data_b;
    assign o_rsp1_data_a = r_rsp1_data_a;
    assign o_rsp1_data_b = r_rsp1_data_b;

    assign o_bank_reg_a  = r_bank_reg_a;
    assign o_bank_reg_b  = r_bank_reg_b;
    assign o_bank_wdata  = r_bank_wdata;
    assign o_bank_rw     = (r_state == ISSUE) && r_we;

endmodule

// File: tb/tb_banco_arbiter.sv
// Bench for banco_arbiter: a behavioural register bank, a transaction-level
// reference model checked every falling edge, and directed scenarios with
// literal expectations.
module tb_banco_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr_a, req0_addr_b;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid, rsp0_ready;
    logic [DW-1:0] rsp0_data_a, rsp0_data_b;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr_a, req1_addr_b;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid, rsp1_ready;
    logic [DW-1:0] rsp1_data_a, rsp1_data_b;
    logic [AW-1:0] bank_reg_a, bank_reg_b;
    logic          bank_rw;
    logic [DW-1:0] bank_wdata, bank_rdata_a, bank_rdata_b;

    banco_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_we(req0_we),
        .i_req0_addr_a(req0_addr_a), .i_req0_addr_b(req0_addr_b), .i_req0_wdata(req0_wdata),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready),
        .o_rsp0_data_a(rsp0_data_a), .o_rsp0_data_b(rsp0_data_b),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_we(req1_we),
        .i_req1_addr_a(req1_addr_a), .i_req1_addr_b(req1_addr_b), .i_req1_wdata(req1_wdata),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready),
        .o_rsp1_data_a(rsp1_data_a), .o_rsp1_data_b(rsp1_data_b),
        .o_bank_reg_a(bank_reg_a), .o_bank_reg_b(bank_reg_b), .o_bank_rw(bank_rw),
        .o_bank_wdata(bank_wdata), .i_bank_rdata_a(bank_rdata_a), .i_bank_rdata_b(bank_rdata_b)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 16'h00AA;
        return 16'hA000 + 16'(i * 17);
    endfunction

    // Register bank: synchronous write, registered read, not affected by rst_n.
    logic [DW-1:0] bank_mem [16];
    bit bank_loaded = 1'b0;
    always @(posedge clk) begin
        if (!bank_loaded) begin
            for (int i = 0; i < 16; i++) bank_mem[i] <= init_val(i);
            bank_loaded <= 1'b1;
        end else if (bank_rw) begin
            bank_mem[bank_reg_a] <= bank_wdata;
        end
        bank_rdata_a <= bank_mem[bank_reg_a];
        bank_rdata_b <= bank_mem[bank_reg_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction view. A grant starts a transaction of
    // age 1..; a write drives the bank at age 1 and answers from age 2, a
    // read answers from age 3, and the response lasts until consumed.
    initial begin : model
        logic [DW-1:0] m_mem [16];
        logic [DW-1:0] m_rsp_a [2];
        logic [DW-1:0] m_rsp_b [2];
        bit            m_busy, m_we, m_last, m_owner;
        int            m_age;
        logic [AW-1:0] m_addr_a, m_addr_b, m_bank_a, m_bank_b;
        logic [DW-1:0] m_wdata;
        bit            e_r0, e_r1, e_rw, e_v0, e_v1, in_rsp, owner_rdy;
        int            gid;
        for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
        m_busy = 0; m_we = 0; m_last = 1; m_owner = 0; m_age = 0;
        m_addr_a = '0; m_addr_b = '0; m_bank_a = '0; m_bank_b = '0; m_wdata = '0;
        m_rsp_a[0] = '0; m_rsp_a[1] = '0; m_rsp_b[0] = '0; m_rsp_b[1] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_last = 1; m_age = 0;
                m_bank_a = '0; m_bank_b = '0;
                m_rsp_a[0] = '0; m_rsp_a[1] = '0; m_rsp_b[0] = '0; m_rsp_b[1] = '0;
                chk("rst_ready0", 32'(req0_ready), 0);
                chk("rst_ready1", 32'(req1_ready), 0);
                chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
                chk("rst_rsp_data", 32'(rsp0_data_a | rsp0_data_b | rsp1_data_a | rsp1_data_b), 0);
                chk("rst_bank", 32'({bank_reg_a, bank_reg_b, bank_rw}), 0);
                chk("rst_bank_wdata", 32'(bank_wdata), 0);
            end else begin
                e_r0 = 0; e_r1 = 0; e_rw = 0; e_v0 = 0; e_v1 = 0; in_rsp = 0; gid = 0;
                if (!m_busy) begin
                    if (req0_valid || req1_valid) begin
                        gid = (req0_valid && req1_valid) ? (m_last ? 0 : 1) : (req1_valid ? 1 : 0);
                        e_r0 = (gid == 0);
                        e_r1 = (gid == 1);
                    end
                end else begin
                    in_rsp = m_we ? (m_age >= 2) : (m_age >= 3);
                    e_rw = m_we && (m_age == 1);
                    e_v0 = in_rsp && !m_owner;
                    e_v1 = in_rsp && m_owner;
                end
                chk("both_ready", 32'(req0_ready && req1_ready), 0);
                chk("ready0", 32'(req0_ready), 32'(e_r0));
                chk("ready1", 32'(req1_ready), 32'(e_r1));
                chk("bank_rw", 32'(bank_rw), 32'(e_rw));
                chk("bank_reg_a", 32'(bank_reg_a), 32'(m_bank_a));
                chk("bank_reg_b", 32'(bank_reg_b), 32'(m_bank_b));
                if (e_rw) chk("bank_wdata", 32'(bank_wdata), 32'(m_wdata));
                chk("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
                chk("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
                chk("rsp0_data_a", 32'(rsp0_data_a), 32'(m_rsp_a[0]));
                chk("rsp0_data_b", 32'(rsp0_data_b), 32'(m_rsp_b[0]));
                chk("rsp1_data_a", 32'(rsp1_data_a), 32'(m_rsp_a[1]));
                chk("rsp1_data_b", 32'(rsp1_data_b), 32'(m_rsp_b[1]));
                // advance the model to the next cycle
                if (!m_busy) begin
                    if (e_r0 || e_r1) begin
                        m_busy = 1; m_age = 1; m_owner = (gid == 1); m_last = (gid == 1);
                        m_we     = gid ? req1_we     : req0_we;
                        m_addr_a = gid ? req1_addr_a : req0_addr_a;
                        m_addr_b = gid ? req1_addr_b : req0_addr_b;
                        m_wdata  = gid ? req1_wdata  : req0_wdata;
                        m_bank_a = m_addr_a;
                        m_bank_b = m_addr_b;
                    end
                end else begin
                    if (m_we && m_age == 1) begin
                        m_mem[m_addr_a] = m_wdata;
                        m_rsp_a[m_owner] = m_wdata;
                    end
                    if (!m_we && m_age == 2) begin
                        m_rsp_a[m_owner] = m_mem[m_addr_a];
                        m_rsp_b[m_owner] = m_mem[m_addr_b];
                    end
                    owner_rdy = m_owner ? rsp1_ready : rsp0_ready;
                    if (in_rsp && owner_rdy) m_busy = 0;
                    else m_age++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int who, output int at_cyc, output int waited);
        who = -1; at_cyc = 0; waited = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                who = req1_ready ? 1 : 0;
                at_cyc = cyc;
                waited = k;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL grant_timeout: no ready within 30 cycles (t=%0t)", $time);
    endtask

    task automatic wait_rsp(input int n);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ((n == 0 && rsp0_valid) || (n == 1 && rsp1_valid)) return;
        end
        checks++; failures++;
        $display("FAIL rsp_timeout: rsp%0d_valid not seen within 30 cycles (t=%0t)", n, $time);
    endtask

    task automatic set_req(input int n, input bit v, input bit we, input int a, input int b, input logic [DW-1:0] wd);
        if (n == 0) begin
            req0_valid = v; req0_we = we; req0_addr_a = AW'(a); req0_addr_b = AW'(b); req0_wdata = wd;
        end else begin
            req1_valid = v; req1_we = we; req1_addr_a = AW'(a); req1_addr_b = AW'(b); req1_wdata = wd;
        end
    endtask

    initial begin : stim
        int who, at, waited, g0;
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 0, 0, 0, 0, '0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();

        // write 0x1234 to r3, then read a=r3 b=r0
        set_req(0, 1, 1, 3, 0, 16'h1234);
        rst_n = 1'b1;
        wait_grant(who, at, waited);
        $display("txn write r3: grant=%0d after %0d cycle(s)", who, waited);
        chk("wr_grant_id", 32'(who), 0);
        chk("first_grant_latency", 32'(waited), 1);
        tick();
        set_req(0, 0, 0, 0, 0, '0);
        chk("wr_bank_rw", 32'(bank_rw), 1);
        chk("wr_bank_reg_a", 32'(bank_reg_a), 3);
        chk("wr_bank_wdata", 32'(bank_wdata), 32'h1234);
        tick();
        chk("wr_bank_rw_one_cycle", 32'(bank_rw), 0);
        chk("wr_echo_valid", 32'(rsp0_valid), 1);
        chk("wr_echo_data_a", 32'(rsp0_data_a), 32'h1234);
        set_req(0, 1, 0, 3, 0, '0);
        wait_grant(who, at, waited);
        tick();
        set_req(0, 0, 0, 0, 0, '0);
        wait_rsp(0);
        $display("txn read r3/r0: data_a=0x%0h data_b=0x%0h", rsp0_data_a, rsp0_data_b);
        chk("raw_data_a", 32'(rsp0_data_a), 32'h1234);
        chk("raw_data_b", 32'(rsp0_data_b), 32'hA000);

        // contention after a fresh reset: 0,1,0,1
        tick();
        rst_n = 1'b0;
        tick(); tick();
        set_req(0, 1, 0, 1, 2, '0);
        set_req(1, 1, 0, 4, 6, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(who, at, waited);
            $display("txn contention %0d: grant=%0d", i, who);
            chk("rr_grant", 32'(who), 32'(i % 2));
        end
        tick();
        set_req(0, 0, 0, 0, 0, '0);
        set_req(1, 0, 0, 0, 0, '0);
        repeat (5) tick();

        // backpressure on rsp1
        rsp1_ready = 1'b0;
        set_req(1, 1, 0, 7, 5, '0);
        wait_grant(who, at, waited);
        chk("bp_grant_id", 32'(who), 1);
        tick();
        set_req(1, 0, 0, 0, 0, '0);
        set_req(0, 1, 0, 2, 3, '0);
        wait_rsp(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("txn backpressure cycle %0d: rsp1_valid=%0b data_a=0x%0h", i, rsp1_valid, rsp1_data_a);
            chk("bp_valid_held", 32'(rsp1_valid), 1);
            chk("bp_data_a", 32'(rsp1_data_a), 32'hA077);
            chk("bp_data_b", 32'(rsp1_data_b), 32'h00AA);
            chk("bp_no_grant", 32'(req0_ready), 0);
        end
        rsp1_ready = 1'b1;
        wait_grant(who, at, waited);
        chk("bp_next_grant", 32'(who), 0);
        tick();
        set_req(0, 0, 0, 0, 0, '0);
        wait_rsp(0);

        // reset during ISSUE of a write to r5
        set_req(0, 1, 1, 5, 5, 16'hBEEF);
        wait_grant(who, at, waited);
        tick();
        set_req(0, 0, 0, 0, 0, '0);
        chk("abort_in_issue", 32'(bank_rw), 1);
        #1;
        rst_n = 1'b0;
        #1;
        $display("txn reset mid-issue: bank_rw=%0b reg_a=%0d wdata=0x%0h", bank_rw, bank_reg_a, bank_wdata);
        chk("abort_bank_rw", 32'(bank_rw), 0);
        chk("abort_bank_reg", 32'({bank_reg_a, bank_reg_b}), 0);
        chk("abort_bank_wdata", 32'(bank_wdata), 0);
        chk("abort_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
        chk("abort_rsp_data", 32'(rsp0_data_a), 0);
        tick(); tick();
        rst_n = 1'b1;
        set_req(0, 1, 0, 5, 5, '0);
        wait_grant(who, at, waited);
        tick();
        set_req(0, 0, 0, 0, 0, '0);
        wait_rsp(0);
        $display("txn read r5 after abort: data_a=0x%0h", rsp0_data_a);
        chk("abort_r5_kept", 32'(rsp0_data_a), 32'h00AA);

        // back-to-back reads from requester 1 only
        tick();
        set_req(1, 1, 0, 9, 10, '0);
        wait_grant(who, at, waited);
        g0 = at;
        for (int i = 0; i < 2; i++) begin
            wait_grant(who, at, waited);
            $display("txn b2b read %0d: grant=%0d interval=%0d", i, who, at - g0);
            chk("b2b_grant_id", 32'(who), 1);
            chk("b2b_interval", 32'(at - g0), 4);
            g0 = at;
        end
        tick();
        set_req(1, 0, 0, 0, 0, '0);
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/banco_arbiter.md
BANCO_ARBITER -- requirements
Module: banco_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 4, SHALL set the register address width (16 registers).
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 reqN_valid  in  1  (N=0,1) requester N presents a command.
REQ-006 reqN_ready  out  1  command from requester N accepted this cycle.
REQ-007 reqN_we  in  1  1=write, 0=read.
REQ-008 reqN_addr_a, reqN_addr_b  in  ADDR_W each  read addresses A/B; addr_a is also the write address.
REQ-009 reqN_wdata  in  DATA_W  write data.
REQ-010 rspN_valid  out  1  response for requester N available.
REQ-011 rspN_ready  in  1  requester N consumes the response.
REQ-012 rspN_data_a, rspN_data_b  out  DATA_W each  read data, or write echo.
REQ-013 bank_reg_a, bank_reg_b  out  ADDR_W each  register-bank address ports.
REQ-014 bank_rw  out  1  register-bank write enable.
REQ-015 bank_wdata  out  DATA_W  register-bank write data.
REQ-016 bank_rdata_a, bank_rdata_b  in  DATA_W each  bank outputs; valid exactly one clk after the address is driven.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP.
REQ-018 In IDLE with one or more reqN_valid: grant one requester and pulse its reqN_ready for exactly one cycle; latch we/addr_a/addr_b/wdata and the owner id; go to ISSUE.
REQ-019 Arbitration SHALL be round-robin: if both are valid, grant the requester other than the last granted; after reset, requester 0 wins the first tie.
REQ-020 At most one reqN_ready SHALL be high per cycle; ready SHALL never be high outside IDLE.
REQ-021 ISSUE: drive the latched addresses on bank_reg_a/b; for a write, assert bank_rw=1 with bank_wdata for exactly this one cycle, then go to RESP; for a read, go to CAPTURE.
REQ-022 CAPTURE: keep the addresses driven; register bank_rdata_a/b into the owner's rsp data; go to RESP.
REQ-023 On a write, rsp data_a SHALL equal the written wdata and data_b SHALL be unchanged.
REQ-024 RESP: hold the owner's rspN_valid=1 and its data stable until rspN_ready=1; on that cycle return to IDLE; the other rspN_valid SHALL stay 0.
REQ-025 Requester inputs SHALL be ignored outside IDLE; a requester SHALL not be granted again while its response is pending.
REQ-026 Read-after-write: a read accepted after a write response SHALL return the new value, because the bank is never written and read in the same transaction.
REQ-027 When not in ISSUE, bank_rw SHALL be 0; bank_reg_a/b SHALL hold their last values.
REQ-028 Throughput: a read SHALL take 4 cycles and a write 3 cycles from grant to IDLE with rsp_ready tied high.

Reset
REQ-029 While rst_n=0, independent of clk: state=IDLE, round-robin pointer favours requester 0, reqN_ready=0, rspN_valid=0, rspN_data_a/b=0, bank_reg_a/b=0, bank_rw=0, bank_wdata=0.
REQ-030 Reset asserted mid-transaction SHALL abort it; no bank write SHALL occur after rst_n falls, and no response SHALL be delivered.
REQ-031 The first grant SHALL be possible on the first rising clk edge after rst_n rises.

Verification
REQ-032 Write-then-read: req0 writes 0x1234 to r3, then reads a=r3, b=r0 -> bank_rw pulses one cycle with bank_reg_a=3; read rsp0 returns data_a=0x1234, data_b=r0 value.
REQ-033 Contention: req0 and req1 both valid continuously -> grants alternate 0,1,0,1, and the first grant goes to 0.
REQ-034 Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid stays 1 with stable data; no new grant until ready=1.
REQ-035 Reset mid-ISSUE of a write to r5 (old value 0x00AA) -> all outputs are 0 immediately; a later read of r5 returns 0x00AA.
REQ-036 Single requester: req1 does back-to-back reads with rsp1_ready=1 -> a new grant every 4 cycles; req0 signals stay 0.
REQ-037 Illegal activity checks: both readys high, ready outside IDLE, or bank_rw outside ISSUE -> the bench flags each as an error.
